count_enable_gen: RTL and testbench
===================================

Name: count_enable_gen

Overview:
Upstream control stage for the 4-bit synchronous JK counter (syncCounter). Generates its counterEn input as a prescaled pulse stream with run, stop, single-step and one-shot modes. Monitors the counter's Q bus (count_q) to flag the wrap cycle and to halt after one full 0..F pass in one-shot mode. Purely single-clock; drives counterEn registered.

Parameters:
PRESCALE_W, 8, width of div input and internal prescaler pre_cnt

Ports:
clk  input  1  system clock, all state updates on posedge
rst  input  1  asynchronous, active-high reset
start  input  1  level, sampled each posedge; request RUN
stop  input  1  level, sampled each posedge; request IDLE
step  input  1  level, sampled each posedge; request one enable pulse (IDLE only)
one_shot  input  1  1 = halt after the pulse that wraps counter F->0
div  input  PRESCALE_W  prescale value; pulse period in RUN = div+1 cycles
count_q  input  4  Q bus of the downstream counter
counterEn  output  1  registered count enable to counter
running  output  1  state == RUN
halted  output  1  state == HALT
wrap  output  1  combinational: counterEn & (count_q == 4'hF)

Behaviour:
- Reset (async, immediate, no clock needed): state=IDLE, pre_cnt=0, counterEn=0. Hence running=0, halted=0, wrap=0.
- States: IDLE=2'b00, RUN=2'b01, STEP=2'b10, HALT=2'b11.
- Command priority, evaluated each posedge: stop > start > step.
- IDLE:
  - start -> RUN, pre_cnt=0.
  - else step -> STEP.
  - counterEn=0.
- STEP:
  - counterEn=1 for exactly this one cycle.
  - Next edge -> IDLE unconditionally. Inputs are ignored in this state, including stop.
- RUN:
  - stop -> IDLE, counterEn=0 next cycle.
  - Else at each edge: if pre_cnt >= div, set counterEn=1 and pre_cnt=0. Otherwise set counterEn=0 and pre_cnt+1.
  - start and step are ignored while in RUN.
- RUN timing:
  - start sampled at edge E gives the first pulse after edge E+1+div.
  - Pulses then repeat every div+1 cycles.
  - div=0 holds counterEn high continuously.
- Live div change: the comparison is >=. If div is lowered below the current pre_cnt, the pulse fires at the next edge. If div is raised, counting continues from the current pre_cnt.
- One-shot:
  - Condition: in RUN with one_shot=1, counterEn=1 and count_q==4'hF in the same cycle.
  - The current pulse completes, so the counter wraps to 0 at the next edge.
  - At that edge the state goes to HALT and counterEn=0, even if pre_cnt >= div. pre_cnt is cleared.
- HALT:
  - counterEn=0.
  - start -> RUN with pre_cnt=0.
  - stop -> IDLE.
  - step is ignored.
- wrap: high in any state during a cycle where counterEn=1 and count_q==F. This marks the cycle before the F->0 edge.
- count_q is treated as the pre-increment value during a counterEn cycle; the counter updates on the following edge.
- pre_cnt saturation: none needed, since it never exceeds max(div) before firing.
- Reset mid-RUN or mid-STEP: counterEn drops immediately; the next start resumes from pre_cnt=0. The counter's own value is untouched, since it has no reset.

Test Plan:
1. Free run:
   - Stimulus: rst pulse; div=0, one_shot=0; start high for 1 cycle.
   - Required: counterEn=1 continuously from the 2nd edge after start. count_q steps 0,1,...,F,0. wrap=1 only while count_q=F.
2. Prescaled run:
   - Stimulus: div=3, start.
   - Required: counterEn is a 1-cycle pulse every 4 cycles, the first at edge E+4. After 8 pulses count_q=8.
3. Single step:
   - Stimulus: in IDLE, hold step for 3 cycles.
   - Required: pulses on alternate cycles (STEP, IDLE, STEP), each exactly 1 cycle wide. count_q advances by 1 per pulse, e.g. 0->1->2.
4. One-shot:
   - Stimulus: one_shot=1, div=0, count_q starting at 0, start.
   - Required: exactly 16 counterEn cycles. count_q ends at 0, halted=1, counterEn=0. A further start gives running=1 and counting resumes.
5. Priority and live div:
   - In RUN, assert stop and start on the same edge -> IDLE, running=0.
   - In RUN with div=9 and pre_cnt=5, change div to 2 -> pulse on the next edge, then every 3 cycles.
6. Async reset:
   - Stimulus: assert rst mid-RUN while counterEn=1, between clock edges.
   - Required: counterEn=0 and running=0 immediately. After release, no pulses until start.

Source files
------------

// File: rtl/count_enable_gen.sv
// Count-enable generator for a 4-bit synchronous counter: prescaled run,
// single-step and one-shot (one full 0..F pass) modes with a registered enable.
module count_enable_gen #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  step,
    input  logic                  one_shot,
    input  logic [PRESCALE_W-1:0] div,
    input  logic [3:0]            count_q,
    output logic                  counterEn,
    output logic                  running,
    output logic                  halted,
    output logic                  wrap
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        HALT = 2'b11
    } state_t;

    state_t                state, state_nxt;
    logic [PRESCALE_W-1:0] pre_cnt, pre_nxt;
    logic                  en_nxt;
    logic                  at_top;

    // count_q is the pre-increment value while counterEn is high.
    assign at_top  = (count_q == 4'hF);
    assign wrap    = counterEn & at_top;
    assign running = (state == RUN);
    assign halted  = (state == HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pre_cnt   <= '0;
            counterEn <= 1'b0;
        end else begin
            state     <= state_nxt;
            pre_cnt   <= pre_nxt;
            counterEn <= en_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pre_nxt   = pre_cnt;
        en_nxt    = 1'b0;
        unique case (state)
            IDLE: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (start) begin
                    state_nxt = RUN;
                    pre_nxt   = '0;
                end else if (step) begin
                    state_nxt = STEP;
                    en_nxt    = 1'b1;
                end
            end
            STEP: begin
                state_nxt = IDLE;
            end
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (one_shot && counterEn && at_top) begin
                    // The wrapping pulse is the one in flight; park afterwards.
                    state_nxt = HALT;
                    pre_nxt   = '0;
                end else if (pre_cnt >= div) begin
                    en_nxt  = 1'b1;
                    pre_nxt = '0;
                end else begin
                    pre_nxt = pre_cnt + PRESCALE_W'(1);
                end
            end
            HALT: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (start) begin
                    state_nxt = RUN;
                    pre_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_count_enable_gen.sv
// Directed bench for count_enable_gen with a behavioural 4-bit counter on count_q.
module tb_count_enable_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, stop = 1'b0, step = 1'b0, one_shot = 1'b0;
    logic [7:0] div = 8'd0;
    logic [3:0] count_q = 4'd0;
    logic       counterEn, running, halted, wrap;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    int         total = 0;
    int         bad = 0;

    count_enable_gen #(.PRESCALE_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step),
        .one_shot(one_shot), .div(div), .count_q(count_q),
        .counterEn(counterEn), .running(running), .halted(halted), .wrap(wrap)
    );

    always #5 clk = ~clk;

    // Downstream counter stand-in: no reset, counts on counterEn.
    always @(posedge clk) begin
        if (load) count_q <= load_val;
        else if (counterEn) count_q <= count_q + 4'd1;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_cq(input logic [3:0] v);
        load = 1'b1; load_val = v;
        cyc(1);
        load = 1'b0;
    endtask

    task automatic go_idle();
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        cyc(1);
    endtask

    task automatic test_reset();
        #2;
        total++; if (counterEn !== 1'b0) begin bad++; $display("FAIL reset_en got=%b exp=0", counterEn); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running got=%b exp=0", running); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
        total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
        cyc(1);
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic test_free_run();
        load_cq(4'd0);
        div = 8'd0; one_shot = 1'b0;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        total++; if (running !== 1'b1 || counterEn !== 1'b0) begin bad++; $display("FAIL free_first run=%b en=%b exp run=1 en=0", running, counterEn); end
        cyc(1);
        for (int i = 0; i < 18; i++) begin
            total++;
            if (counterEn !== 1'b1 || count_q !== 4'(i) || wrap !== (i % 16 == 15)) begin
                bad++; $display("FAIL free_run i=%0d en=%b q=%h wrap=%b exp en=1 q=%h wrap=%b", i, counterEn, count_q, wrap, 4'(i), (i % 16 == 15));
            end
            cyc(1);
        end
        go_idle();
        total++; if (running !== 1'b0 || counterEn !== 1'b0) begin bad++; $display("FAIL free_stop run=%b en=%b exp 0 0", running, counterEn); end
    endtask

    task automatic test_prescaled();
        load_cq(4'd0);
        div = 8'd3;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            cyc(1);
            total++;
            if (counterEn !== (c % 4 == 0)) begin bad++; $display("FAIL presc_en c=%0d got=%b exp=%b", c, counterEn, (c % 4 == 0)); end
        end
        cyc(1);
        total++; if (count_q !== 4'd8) begin bad++; $display("FAIL presc_count got=%h exp=8", count_q); end
        go_idle();
    endtask

    task automatic test_step();
        logic [3:0] exp_q [4];
        logic       exp_en [4];
        exp_q  = '{4'd0, 4'd1, 4'd1, 4'd2};
        exp_en = '{1'b1, 1'b0, 1'b1, 1'b0};
        load_cq(4'd0);
        step = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            if (k == 2) step = 1'b0;
            total++;
            if (counterEn !== exp_en[k] || count_q !== exp_q[k] || running !== 1'b0) begin
                bad++; $display("FAIL step k=%0d en=%b q=%h run=%b exp en=%b q=%h run=0", k, counterEn, count_q, running, exp_en[k], exp_q[k]);
            end
        end
        cyc(1);
    endtask

    task automatic test_one_shot();
        int n_en = 0;
        load_cq(4'd0);
        one_shot = 1'b1; div = 8'd0;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        for (int c = 0; c < 24; c++) begin
            if (counterEn === 1'b1) n_en++;
            cyc(1);
        end
        total++; if (n_en != 16) begin bad++; $display("FAIL oneshot_pulses got=%0d exp=16", n_en); end
        total++; if (count_q !== 4'd0 || halted !== 1'b1 || counterEn !== 1'b0) begin
            bad++; $display("FAIL oneshot_end q=%h halted=%b en=%b exp q=0 halted=1 en=0", count_q, halted, counterEn); end
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        total++; if (halted !== 1'b1 || counterEn !== 1'b0) begin bad++; $display("FAIL halt_step halted=%b en=%b exp 1 0", halted, counterEn); end
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        total++; if (running !== 1'b1) begin bad++; $display("FAIL halt_restart run=%b exp=1", running); end
        cyc(2);
        total++; if (counterEn !== 1'b1 || count_q !== 4'd1) begin bad++; $display("FAIL resume en=%b q=%h exp en=1 q=1", counterEn, count_q); end
        one_shot = 1'b0;
        go_idle();
    endtask

    task automatic test_priority_div();
        div = 8'd5;
        start = 1'b1;
        cyc(3);
        stop = 1'b1;
        cyc(1);
        start = 1'b0; stop = 1'b0;
        total++; if (running !== 1'b0 || counterEn !== 1'b0) begin bad++; $display("FAIL prio_stop run=%b en=%b exp 0 0", running, counterEn); end
        cyc(1);
        div = 8'd9;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            cyc(1);
            if (c == 5) div = 8'd2;
            total++;
            if (counterEn !== (c == 6 || c == 9 || c == 12)) begin
                bad++; $display("FAIL live_div c=%0d got=%b exp=%b", c, counterEn, (c == 6 || c == 9 || c == 12));
            end
        end
        go_idle();
    endtask

    task automatic test_async_reset();
        div = 8'd0;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
        total++; if (counterEn !== 1'b1) begin bad++; $display("FAIL ares_pre en=%b exp=1", counterEn); end
        #2 rst = 1'b1;
        #1;
        total++; if (counterEn !== 1'b0 || running !== 1'b0) begin bad++; $display("FAIL ares_now en=%b run=%b exp 0 0", counterEn, running); end
        #1 rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cyc(1);
            total++;
            if (counterEn !== 1'b0 || running !== 1'b0) begin bad++; $display("FAIL ares_after c=%0d en=%b run=%b exp 0 0", c, counterEn, running); end
        end
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
        total++; if (counterEn !== 1'b1 || running !== 1'b1) begin bad++; $display("FAIL ares_restart en=%b run=%b exp 1 1", counterEn, running); end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_prescaled();
        test_step();
        test_one_shot();
        test_priority_div();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
